// File: rtl/ex_muldiv_seq_pkg.sv
// Shared EX-stage definitions for the iterative RV32M multiply/divide unit.
// The DIV state encoding exists only when RV32_MULDIV_DIV_EN is defined.
package ex_muldiv_seq_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef RV32_MULDIV_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_e;

  localparam int         ITER_COUNT = 32;
  localparam logic [4:0] ITER_LAST  = 5'(ITER_COUNT - 1);

  function automatic logic f_rs1_signed(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic f_rs2_signed(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  // Conditional two's-complement negate; also yields the magnitude of a signed operand.
  function automatic logic [31:0] f_cneg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, restore.
// Compiled only when RV32_MULDIV_DIV_EN is defined.
`ifdef RV32_MULDIV_DIV_EN
module ex_div_step (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_dvsr,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);

  logic [32:0] w_shift;
  logic [32:0] w_diff;

  assign w_shift = {i_rem, i_quo[31]};
  assign w_diff  = w_shift - {1'b0, i_dvsr};

  // Partial remainder stays below the divisor, so a borrow out of bit 32 means "restore".
  always_comb begin
    o_rem = w_diff[31:0];
    o_quo = {i_quo[30:0], 1'b1};
    if (w_diff[32]) begin
      o_rem = w_shift[31:0];
      o_quo = {i_quo[30:0], 1'b0};
    end
  end

endmodule
`endif

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the EX stage (32 radix-2 iterations).
// Divider datapath and DIV state are built only when RV32_MULDIV_DIV_EN is defined.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [4:0]  r_cnt;
  op_e         r_op;
  logic [63:0] r_prod;
  logic [31:0] r_opnd;
  logic        r_neg;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_s1_neg;
  logic        w_s2_neg;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_nxt;
  logic [63:0] w_mul_fin;

  assign w_accept = (r_state == ST_IDLE) && start && !flush;
  assign w_s1_neg = f_rs1_signed(op) && rs1[31];
  assign w_s2_neg = f_rs2_signed(op) && rs2[31];
  assign w_mag1   = f_cneg(rs1, w_s1_neg);
  assign w_mag2   = f_cneg(rs2, w_s2_neg);

  // r_prod holds {partial product, remaining multiplier bits}; r_opnd is the multiplicand.
  assign w_mul_sum = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_nxt = {w_mul_sum, r_prod[31:1]};
  assign w_mul_fin = r_neg ? (~w_mul_nxt + 64'd1) : w_mul_nxt;

`ifdef RV32_MULDIV_DIV_EN
  logic        r_rem_neg;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic [31:0] w_step_rem;
  logic [31:0] w_step_quo;
  logic [31:0] w_div_quo;
  logic [31:0] w_div_rem;

  assign w_div_zero = (rs2 == 32'd0);
  assign w_div_ovf  = !op[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

  // For division r_prod holds {partial remainder, dividend/quotient}; r_opnd is the divisor.
  ex_div_step u_div_step (
    .i_rem  (r_prod[63:32]),
    .i_quo  (r_prod[31:0]),
    .i_dvsr (r_opnd),
    .o_rem  (w_step_rem),
    .o_quo  (w_step_quo)
  );

  assign w_div_quo = f_cneg(w_step_quo, r_neg);
  assign w_div_rem = f_cneg(w_step_rem, r_rem_neg);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !flush) begin
          if (!op[2]) w_state_nxt = ST_MUL;
`ifdef RV32_MULDIV_DIV_EN
          else if (w_div_zero || w_div_ovf) w_state_nxt = ST_DONE;
          else w_state_nxt = ST_DIV;
`else
          else w_state_nxt = ST_DONE;
`endif
        end
      end
      ST_MUL: begin
        busy = 1'b1;
        if (flush) w_state_nxt = ST_IDLE;
        else if (r_cnt == ITER_LAST) w_state_nxt = ST_DONE;
      end
`ifdef RV32_MULDIV_DIV_EN
      ST_DIV: begin
        busy = 1'b1;
        if (flush) w_state_nxt = ST_IDLE;
        else if (r_cnt == ITER_LAST) w_state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 5'd0;
      r_op     <= OP_MUL;
      r_prod   <= 64'd0;
      r_opnd   <= 32'd0;
      r_neg    <= 1'b0;
      r_result <= 32'd0;
`ifdef RV32_MULDIV_DIV_EN
      r_rem_neg <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt <= 5'd0;
      r_op  <= op_e'(op);
      r_neg <= w_s1_neg ^ w_s2_neg;
      if (!op[2]) begin
        r_prod <= {32'd0, w_mag2};
        r_opnd <= w_mag1;
      end else begin
`ifdef RV32_MULDIV_DIV_EN
        r_prod    <= {32'd0, w_mag1};
        r_opnd    <= w_mag2;
        r_rem_neg <= w_s1_neg;
        if (w_div_zero)     r_result <= op[1] ? rs1 : 32'hFFFF_FFFF;
        else if (w_div_ovf) r_result <= op[1] ? 32'd0 : 32'h8000_0000;
`else
        r_result <= 32'd0;
`endif
      end
    end else if (r_state == ST_MUL && !flush) begin
      r_cnt  <= r_cnt + 5'd1;
      r_prod <= w_mul_nxt;
      if (r_cnt == ITER_LAST)
        r_result <= (r_op == OP_MUL) ? w_mul_fin[31:0] : w_mul_fin[63:32];
    end
`ifdef RV32_MULDIV_DIV_EN
    else if (r_state == ST_DIV && !flush) begin
      r_cnt  <= r_cnt + 5'd1;
      r_prod <= {w_step_rem, w_step_quo};
      if (r_cnt == ITER_LAST)
        r_result <= r_op[1] ? w_div_rem : w_div_quo;
    end
`endif
  end

  assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed RV32M corner cases plus random ops
// against an arithmetic reference model. Expectations follow RV32_MULDIV_DIV_EN.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (failure #%0d)", tag, obs, exp, n_fail);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result straight from the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] f_op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] qa;
    logic signed [31:0] qb;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    qa  = a;
    qb  = b;
    up  = {32'd0, a} * {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ref_result = 32'd0;
    case (f_op)
      3'd0: ref_result = up[31:0];
      3'd1: begin sp = sa * sb; ref_result = sp[63:32]; end
      3'd2: begin sp = sa * $signed({32'd0, b}); ref_result = sp[63:32]; end
      3'd3: ref_result = up[63:32];
`ifdef RV32_MULDIV_DIV_EN
      3'd4: ref_result = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : qa / qb;
      3'd5: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_result = (b == 0) ? a : ovf ? 32'd0 : qa % qb;
      3'd7: ref_result = (b == 0) ? a : a % b;
`endif
      default: ref_result = 32'd0;
    endcase
  endfunction

  // Cycles from the accepting edge until done is seen.
  function automatic int ref_lat(input logic [2:0] f_op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!f_op[2]) return 33;
`ifdef RV32_MULDIV_DIV_EN
    if (b == 32'd0) return 1;
    if (!f_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  // Issue one op in the current cycle; optionally poke start while busy (poke_at)
  // and in the DONE cycle (poke_done) to prove both are ignored.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int poke_at, input bit poke_done);
    int          lat;
    int          exp_lat;
    bit          busy_ok;
    logic [31:0] exp_r;
    exp_r   = ref_result(o, a, b);
    exp_lat = ref_lat(o, a, b);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    tick();
    start = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    lat = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      start = (lat == poke_at);
      if (start) begin op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; end
      tick();
      lat++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_result"}, result, exp_r);
    start = poke_done;
    if (poke_done) begin op = 3'd0; rs1 = $urandom; rs2 = $urandom; end
    tick();
    start = 1'b0;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold"}, result, exp_r);
    if (poke_done) chk({tag, "_done_start_ignored"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [2:0]  fl_op;
    logic [31:0] prev;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  ro;
    int          ndone;

    // Reset dominates start and flush.
    rst = 1'b1; start = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd5;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    run_op(3'd0, 32'd7, 32'd6, "mul_7x6", 0, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min", 0, 1'b0);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, "mulhu_min", 0, 1'b0);
    run_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, "mul_poke", 3, 1'b1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu_neg1x2", 0, 1'b0);

    // Reset in cycle N+5 of a multiply aborts it without a done pulse.
    start = 1'b1; op = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("rst_mid_no_done", 32'(ndone), 32'd0);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 0, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 0, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, "divu_by0", 0, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 2, 1'b1);
    run_op(3'd7, 32'd100, 32'd7, "remu_100_7", 0, 1'b0);

    // Flush in cycle N+10 of an iterative op, then a new start at N+11.
`ifdef RV32_MULDIV_DIV_EN
    fl_op = 3'd5;
`else
    fl_op = 3'd0;
`endif
    prev = result;
    start = 1'b1; op = fl_op; rs1 = $urandom; rs2 = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result", result, prev);
    run_op(fl_op, 32'd1000, 32'd7, "after_flush", 0, 1'b0);

    // Flush together with start in IDLE discards the start.
    prev = result;
    start = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("flush_start_done", {31'd0, done}, 32'd0);
    chk("flush_start_result", result, prev);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 99));
        default: ;
      endcase
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro), 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
